// File: rtl/geofence_cross_arbiter.sv
// Round-robin arbiter feeding a shared 3-stage signed cross-product pipeline:
// C = (ax-kx)*(by-ky) - (bx-kx)*(ay-ky), returned with the requester ID.
module geofence_cross_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 10,
  parameter int IDW  = 2,
  parameter int RW   = 2*CW+2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*6*CW-1:0]     opnd,
  output logic [NREQ-1:0]          gnt,
  output logic                     res_valid,
  output logic [IDW-1:0]           res_id,
  output logic signed [RW-1:0]     res_val,
  output logic                     res_neg,
  output logic                     res_zero,
  output logic                     busy
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic [CW-1:0] ax;
    logic [CW-1:0] ay;
    logic [CW-1:0] bx;
    logic [CW-1:0] by;
    logic [CW-1:0] kx;
    logic [CW-1:0] ky;
  } opnd_t;

  function automatic logic signed [RW-1:0] sx(input logic signed [CW:0] v);
    return {{(RW-CW-1){v[CW]}}, v};
  endfunction

  opnd_t                   lane_op [NREQ];
  opnd_t                   sel_op;
  logic [NREQ-1:0]         gnt_c;
  logic [IDW-1:0]          gnt_idx;
  logic                    found;
  logic [IDW:0]            idx_w;
  logic [IDW-1:0]          idx;

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [STAGES-1:0]       vld_pipe_q, vld_pipe_d;
  logic signed [CW:0]      dax_q, day_q, dbx_q, dby_q;
  logic signed [CW:0]      dax_d, day_d, dbx_d, dby_d;
  logic [IDW-1:0]          id1_q, id1_d, id2_q, id2_d, res_id_q, res_id_d;
  logic signed [RW-1:0]    p1_q, p1_d, p2_q, p2_d, res_val_q, res_val_d;
  logic                    res_neg_q, res_neg_d, res_zero_q, res_zero_d;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign lane_op[i] = opnd[i*6*CW +: 6*CW];
  end

  // Rotating priority search starting at ptr_q; nothing is granted while in reset.
  always_comb begin
    gnt_c   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx_w   = '0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_w = {1'b0, ptr_q} + (IDW+1)'(k);
      if (idx_w >= (IDW+1)'(NREQ)) idx_w = idx_w - (IDW+1)'(NREQ);
      idx = idx_w[IDW-1:0];
      if (!found && !reset && req[idx]) begin
        found      = 1'b1;
        gnt_idx    = idx;
        gnt_c[idx] = 1'b1;
      end
    end
  end

  // One-hot AND-OR select keeps unselected lanes (and any X on them) out of the datapath.
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_c[i]) sel_op = sel_op | lane_op[i];
  end

  always_comb begin
    ptr_d      = ptr_q;
    vld_pipe_d = {vld_pipe_q[STAGES-2:0], found};
    dax_d      = dax_q;
    day_d      = day_q;
    dbx_d      = dbx_q;
    dby_d      = dby_q;
    id1_d      = id1_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    id2_d      = id2_q;
    res_val_d  = res_val_q;
    res_id_d   = res_id_q;
    res_neg_d  = res_neg_q;
    res_zero_d = res_zero_q;
    if (found) begin
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      dax_d = $signed({1'b0, sel_op.ax}) - $signed({1'b0, sel_op.kx});
      day_d = $signed({1'b0, sel_op.ay}) - $signed({1'b0, sel_op.ky});
      dbx_d = $signed({1'b0, sel_op.bx}) - $signed({1'b0, sel_op.kx});
      dby_d = $signed({1'b0, sel_op.by}) - $signed({1'b0, sel_op.ky});
      id1_d = gnt_idx;
    end
    if (vld_pipe_q[0]) begin
      p1_d  = sx(dax_q) * sx(dby_q);
      p2_d  = sx(dbx_q) * sx(day_q);
      id2_d = id1_q;
    end
    // Output registers only update on a valid entry so they hold between results.
    if (vld_pipe_q[1]) begin
      res_val_d  = p1_q - p2_q;
      res_neg_d  = res_val_d[RW-1];
      res_zero_d = (res_val_d == '0);
      res_id_d   = id2_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      vld_pipe_q <= '0;
      dax_q      <= '0;
      day_q      <= '0;
      dbx_q      <= '0;
      dby_q      <= '0;
      id1_q      <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      id2_q      <= '0;
      res_val_q  <= '0;
      res_id_q   <= '0;
      res_neg_q  <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      vld_pipe_q <= vld_pipe_d;
      dax_q      <= dax_d;
      day_q      <= day_d;
      dbx_q      <= dbx_d;
      dby_q      <= dby_d;
      id1_q      <= id1_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      id2_q      <= id2_d;
      res_val_q  <= res_val_d;
      res_id_q   <= res_id_d;
      res_neg_q  <= res_neg_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign gnt       = gnt_c;
  assign res_valid = vld_pipe_q[STAGES-1];
  assign res_id    = res_id_q;
  assign res_val   = res_val_q;
  assign res_neg   = res_neg_q;
  assign res_zero  = res_zero_q;
  assign busy      = |vld_pipe_q;

endmodule

// File: tb/tb_geofence_cross_arbiter.sv
// Directed bench for geofence_cross_arbiter: expected results are queued with their
// due cycle and every cycle checks res_valid/res_id/res_val/flags and busy.
module tb_geofence_cross_arbiter;
  localparam int NREQ = 4;
  localparam int CW   = 10;
  localparam int IDW  = 2;
  localparam int RW   = 2*CW+2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*6*CW-1:0]  opnd = '0;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic signed [RW-1:0]  res_val;
  logic                  res_neg, res_zero, busy;

  geofence_cross_arbiter #(.NREQ(NREQ), .CW(CW), .IDW(IDW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .req(req), .opnd(opnd), .gnt(gnt),
    .res_valid(res_valid), .res_id(res_id), .res_val(res_val),
    .res_neg(res_neg), .res_zero(res_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int id; int val; } exp_t;
  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [6*CW-1:0] pk(input int ax, input int ay, input int bx,
                                         input int by, input int kx, input int ky);
    return {ax[CW-1:0], ay[CW-1:0], bx[CW-1:0], by[CW-1:0], kx[CW-1:0], ky[CW-1:0]};
  endfunction

  task automatic set_op(input int i, input logic [6*CW-1:0] v);
    opnd[i*6*CW +: 6*CW] = v;
  endtask

  // Client i default operands: a=(i+1,0), b=(0,1), k=(0,0) -> C = i+1.
  task automatic set_defaults();
    for (int i = 0; i < NREQ; i++) set_op(i, pk(i+1, 0, 0, 1, 0, 0));
  endtask

  // Advance to the next negedge and check the registered outputs against the queue.
  task automatic tick();
    @(negedge clk);
    cyc++;
    check("busy", busy, (q.size() != 0));
    if (q.size() != 0 && q[0].due == cyc) begin
      check("res_valid", res_valid, 1);
      check("res_id", res_id, q[0].id);
      check("res_val", res_val, q[0].val);
      check("res_neg", res_neg, (q[0].val < 0));
      check("res_zero", res_zero, (q[0].val == 0));
      void'(q.pop_front());
    end else begin
      check("res_valid_idle", res_valid, 0);
    end
  endtask

  // Check the combinational grant after inputs settle; queue the result 3 cycles out.
  task automatic grant(input int exp_gnt, input int id, input int val);
    #1;
    check("gnt", gnt, exp_gnt);
    if (exp_gnt != 0) q.push_back('{cyc + 3, id, val});
  endtask

  initial begin
    // Reset state with all requests pending: nothing granted, outputs cleared.
    req = '1;
    set_defaults();
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_val", res_val, 0);
    check("rst_res_neg", res_neg, 0);
    check("rst_res_zero", res_zero, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    req   = '0;

    // Single request: 3*4 - 0*0 = 12.
    tick(); set_op(0, pk(3, 0, 0, 4, 0, 0)); req = 4'b0001; grant(1, 0, 12);
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick(); tick();
    check("hold_val", res_val, 12);
    check("hold_id", res_id, 0);

    // Sign and collinear on client 1, back-to-back with req held.
    tick(); set_op(1, pk(0, 4, 3, 0, 0, 0)); req = 4'b0010; grant(2, 1, -12);
    tick(); set_op(1, pk(2, 2, 4, 4, 0, 0)); grant(2, 1, 0);
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick();

    // Round robin from a fresh reset: all clients requesting for 8 cycles.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; set_defaults(); req = '1; grant(1, 0, 1);
    for (int n = 1; n < 8; n++) begin
      tick(); grant(1 << (n % 4), n % 4, n % 4 + 1);
    end
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick();

    // Wrap/skip: grant 3, then 0101 -> 0 then 2, pointer lands on 3.
    tick(); req = 4'b1000; grant(8, 3, 4);
    tick(); req = 4'b0101; grant(1, 0, 1);
    tick(); req = 4'b0100; grant(4, 2, 3);
    tick(); req = 4'b1111; grant(8, 3, 4);
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick();

    // Coordinate extremes on client 0, one grant per cycle.
    tick(); req = 4'b0001; set_op(0, pk(1023, 0, 0, 1023, 0, 0)); grant(1, 0, 1046529);
    tick(); set_op(0, pk(0, 1023, 1023, 0, 0, 0));    grant(1, 0, -1046529);
    tick(); set_op(0, pk(1023, 0, 0, 0, 0, 1023));    grant(1, 0, -1046529);
    tick(); set_op(0, pk(0, 0, 1023, 0, 1023, 1023)); grant(1, 0, 1046529);
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick();

    // Reset one cycle after a grant: entry is dropped, pointer returns to 0.
    tick(); set_op(0, pk(9, 0, 0, 9, 0, 0)); req = 4'b0001; grant(1, 0, 81);
    tick(); req = '0;
    reset = 1'b1;
    #1;
    q.delete();
    check("rst_mid_busy", busy, 0);
    check("rst_mid_valid", res_valid, 0);
    check("rst_mid_gnt", gnt, 0);
    tick(); reset = 1'b0;
    tick(); tick(); tick();
    // 4*2 - 1*6 = 2 for a=(5,7), b=(2,3), k=(1,1); ptr=0 picks client 0 over 3.
    set_op(0, pk(5, 7, 2, 3, 1, 1)); req = 4'b1001; grant(1, 0, 2);
    tick(); req = '0; grant(0, 0, 0);
    tick(); tick(); tick();

    if (q.size() != 0) check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
